// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared constants, FSM state types and helpers for the AXI4-Lite RAM slave
//
// Contents:
//   RESP_OKAY / RESP_SLVERR : BRESP/RRESP codes
//   w_state_e               : write channel FSM states
//   r_state_e               : read channel FSM states
//   bytes_log2()            : log2 of bytes per data word (byte-offset bits in an address)

package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'b00,
        W_HAVE_AW = 2'b01,
        W_HAVE_W  = 2'b10,
        W_RESP    = 2'b11
    } w_state_e;

    // Two bits wide so that the unused encodings exist and fall back to R_IDLE.
    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_DATA = 2'b01
    } r_state_e;

    function automatic int bytes_log2(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi4_lite_ram_slave_if.sv
// rtl/axi4_lite_ram_slave_if.sv - AXI4-Lite bus interface with master and slave modports
//
// Parameters: ADDR_W (byte-address width), DATA_W (32 or 64)
// Signals:
//   AW channel : AWADDR, AWVALID, AWREADY
//   W  channel : WDATA, WSTRB, WVALID, WREADY
//   B  channel : BRESP, BVALID, BREADY
//   AR channel : ARADDR, ARVALID, ARREADY
//   R  channel : RDATA, RRESP, RVALID, RREADY

interface axi4_lite_ram_slave_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0]     AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_W-1:0]     ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axi4_lite_ram_mem.sv
// rtl/axi4_lite_ram_mem.sv - single-clock DEPTH x DATA_W RAM, byte-enabled write port, registered read port
//
// Ports:
//   clk       : clock
//   we_i      : write enable (gated per byte by wstrb_i)
//   waddr_i   : write word index
//   wdata_i   : write data
//   wstrb_i   : byte enables
//   re_i      : read enable; rdata_o is loaded only when set, otherwise held
//   raddr_i   : read word index
//   rdata_o   : registered read data (old contents when reading the word being written)

module axi4_lite_ram_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                re_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Both updates are non-blocking on the same edge, so a read of the word
    // being written returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_lite_ram_slave.sv
// rtl/axi4_lite_ram_slave.sv - AXI4-Lite slave with built-in word RAM and independent read/write FSMs
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset; aborts in-flight transactions, RAM not cleared
//   bus  : axi4_lite_ram_slave_if.slave (AW, W, B, AR, R channels)
// Parameters: ADDR_W (byte address), DATA_W (32/64), DEPTH (words, DEPTH*DATA_W/8 <= 2**ADDR_W)
// Build option: AXI_RAM_ERR_RESP_EN
//   defined   - out-of-range reads return SLVERR with zero data, out-of-range writes are dropped with SLVERR
//   undefined - word index wraps modulo DEPTH and responses are always OKAY

module axi4_lite_ram_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    axi4_lite_ram_slave_if.slave bus
);

    localparam int          OFF     = bytes_log2(DATA_W);
    localparam int          STRB_W  = DATA_W / 8;
    localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = DEPTH;

    // Word index of a byte address; low byte-offset bits are ignored.
    function automatic logic [MEM_AW-1:0] map_idx(input logic [ADDR_W-1:0] a);
        logic [31:0] idx;
        idx = 32'(a[ADDR_W-1:OFF]);
`ifdef AXI_RAM_ERR_RESP_EN
        return idx[MEM_AW-1:0];
`else
        return MEM_AW'(idx % DEPTH_U);
`endif
    endfunction

`ifdef AXI_RAM_ERR_RESP_EN
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a[ADDR_W-1:OFF]) < DEPTH_U;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_e            w_state_q;
    logic                awready_q;
    logic                wready_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    logic                aw_hs;
    logic                w_hs;
    logic                commit;
    logic                wr_ok;
    logic [1:0]          commit_resp;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;

    // Readies are forced low by reset, but gating with rst also keeps a
    // handshake that coincides with the reset edge from reaching the RAM.
    assign aw_hs = !rst && bus.AWVALID && awready_q;
    assign w_hs  = !rst && bus.WVALID  && wready_q;

    // The write completes on the edge where the second of AW/W arrives;
    // whichever half came first is taken from its holding register.
    always_comb begin
        commit  = 1'b0;
        wr_addr = bus.AWADDR;
        wr_data = bus.WDATA;
        wr_strb = bus.WSTRB;
        case (w_state_q)
            W_IDLE: begin
                commit = aw_hs && w_hs;
            end
            W_HAVE_AW: begin
                commit  = w_hs;
                wr_addr = awaddr_q;
            end
            W_HAVE_W: begin
                commit  = aw_hs;
                wr_data = wdata_q;
                wr_strb = wstrb_q;
            end
            default: begin
                commit = 1'b0;
            end
        endcase
    end

`ifdef AXI_RAM_ERR_RESP_EN
    assign wr_ok = in_range(wr_addr);
`else
    assign wr_ok = 1'b1;
`endif
    assign commit_resp = wr_ok ? RESP_OKAY : RESP_SLVERR;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (commit) begin
                        w_state_q <= W_RESP;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= commit_resp;
                    end else if (aw_hs) begin
                        w_state_q <= W_HAVE_AW;
                        awaddr_q  <= bus.AWADDR;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                    end else if (w_hs) begin
                        w_state_q <= W_HAVE_W;
                        wdata_q   <= bus.WDATA;
                        wstrb_q   <= bus.WSTRB;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                    end else begin
                        // Also raises the readies on the first cycle out of reset.
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (commit) begin
                        w_state_q <= W_RESP;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= commit_resp;
                    end
                end
                W_HAVE_W: begin
                    if (commit) begin
                        w_state_q <= W_RESP;
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= commit_resp;
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_e     r_state_q;
    logic         arready_q;
    logic         rvalid_q;
    logic [1:0]   rresp_q;
    logic         rzero_q;
    logic         ar_hs;
    logic         rd_ok;

    assign ar_hs = !rst && bus.ARVALID && arready_q;

`ifdef AXI_RAM_ERR_RESP_EN
    assign rd_ok = in_range(bus.ARADDR);
`else
    assign rd_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rzero_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_q <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rzero_q   <= !rd_ok;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.RREADY) begin
                        r_state_q <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rresp_q   <= RESP_OKAY;
                        rzero_q   <= 1'b0;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b1;
                    rresp_q   <= RESP_OKAY;
                    rzero_q   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_rdata;

    axi4_lite_ram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (commit && wr_ok),
        .waddr_i (map_idx(wr_addr)),
        .wdata_i (wr_data),
        .wstrb_i (wr_strb),
        .re_i    (ar_hs),
        .raddr_i (map_idx(bus.ARADDR)),
        .rdata_o (mem_rdata)
    );

    // The RAM read register is not reset; RDATA is qualified by RVALID so it
    // reads zero in reset and idle, and by rzero_q for out-of-range reads.
    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RDATA   = (rvalid_q && !rzero_q) ? mem_rdata : '0;

endmodule

// File: doc/axi4_lite_ram_slave.md
Name: axi4_lite_ram_slave

Overview:
- AXI4-Lite slave with built-in parametrised word RAM; next generation of the single-FSM AXI4-Lite controller.
- Independent read and write FSMs: a read and a write may be in flight concurrently.
- AW and W are accepted in either order or together; WSTRB byte enables are honoured; out-of-range accesses return an error response.
- Sits between the interconnect and local memory-mapped storage.

Parameters:
ADDR_W, 12, byte-address width
DATA_W, 32, data width; 32 or 64 only
DEPTH, 1024, number of words; must satisfy DEPTH*(DATA_W/8) <= 2**ADDR_W

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
AWADDR  in  ADDR_W  write byte address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_W  read byte address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_W  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset:
  - rst is sampled on clk; it takes effect immediately in any state and aborts in-flight transactions.
  - While rst is high, all READY/VALID outputs are 0; BRESP, RRESP and RDATA are 0.
  - RAM contents are not cleared.
  - First cycle after rst deasserts: AWREADY, WREADY and ARREADY are 1.
- Addressing:
  - Word index = ADDR[ADDR_W-1 : log2(DATA_W/8)].
  - Low address bits are ignored; unaligned accesses are treated as aligned.
  - An index >= DEPTH is out of range.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE:
    - AWREADY=1, WREADY=1.
    - AW handshake only -> W_HAVE_AW (latch AWADDR).
    - W handshake only -> W_HAVE_W (latch WDATA and WSTRB).
    - Both in the same cycle -> commit write, go to W_RESP.
  - W_HAVE_AW: AWREADY=0, WREADY=1; W handshake -> commit, go to W_RESP.
  - W_HAVE_W: WREADY=0, AWREADY=1; AW handshake -> commit, go to W_RESP.
  - W_RESP:
    - BVALID=1; BRESP is held stable until the handshake.
    - BREADY -> W_IDLE.
    - No new AW or W is accepted in this state.
  - Commit: the RAM is written at the clock edge of the completing handshake.
    - Only bytes with WSTRB[i]=1 are updated.
    - WSTRB=0 is legal: nothing is written and the response is OKAY.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1; AR handshake -> register RDATA/RRESP from the RAM at that edge, go to R_DATA.
  - R_DATA:
    - RVALID=1; RDATA and RRESP are held stable.
    - ARREADY=0.
    - RREADY -> R_IDLE.
  - Latency: RVALID rises the cycle after the AR handshake.
  - Back-to-back reads give at most one read per 2 cycles; writes likewise.
- Read/write collision:
  - An AR handshake on the same edge as a write commit to the same word returns the OLD data.
  - A later read returns the new data.
- Response codes: OKAY=2'b00, SLVERR=2'b10.
- Unused state encodings recover to the idle state.

Optional Feature:
- Macro: AXI_RAM_ERR_RESP_EN.
- Defined:
  - An out-of-range read returns RRESP=SLVERR and RDATA=0.
  - An out-of-range write is suppressed and returns BRESP=SLVERR.
- Undefined:
  - The word index is taken modulo DEPTH, so accesses alias.
  - RRESP and BRESP are always OKAY.

Decomposition:
- Package axi4_lite_pkg:
  - RESP_OKAY and RESP_SLVERR constants.
  - Write and read FSM state typedefs.
  - Function for log2 of bytes per word.
- Sub-module axi4_lite_ram_mem:
  - Synchronous single-clock RAM, DEPTH x DATA_W.
  - One byte-enabled write port and one registered read port.
  - Read-before-write on the same address.

Test Plan:
- Reset during W_HAVE_AW (AWADDR=0x010 accepted, no W yet), then rst=1 for 1 cycle -> all VALID/READY=0 during reset; AWREADY/WREADY/ARREADY=1 the next cycle; word 4 is unchanged.
- W before AW: WDATA=0xDEADBEEF, WSTRB=4'b0101 two cycles before AWADDR=0x008 -> BVALID the cycle after the AW handshake, BRESP=00; a read of 0x008 from 0x00000000 returns 0x00AD00EF.
- Simultaneous AW+W and AR to 0x004 on the same cycle (old value 0x11111111, new 0x22222222) -> RDATA=0x11111111; a next read returns 0x22222222.
- BREADY held low for 5 cycles -> BVALID stays 1 and BRESP stays stable; AWREADY=0 and WREADY=0 throughout.
- RREADY held low -> RDATA stable, ARREADY=0; meanwhile a concurrent write completes with BRESP=00.
- With AXI_RAM_ERR_RESP_EN, read of 0x1000-4 when DEPTH=512 -> RRESP=10, RDATA=0; write there -> BRESP=10 and no RAM change. Without the macro, the same read returns word 511 with RRESP=00.
